// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner with row synchronizer, frame-level debounce and a keycode FIFO,
// read through an 8-bit data/status register pair.
module keypad_scan_ctrl #(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   input  logic       re,
   input  logic       addr,
   output logic [7:0] data_out,
   output logic       irq
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [DB_W-1:0]  DB_MAX    = DB_W'(DEBOUNCE_SCANS);
   localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      CLS_NONE  = 2'd0,
      CLS_ONE   = 2'd1,
      CLS_MULTI = 2'd2
   } cls_t;

   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'h0;
         4'b11_01: code = 4'hF;
         4'b11_10: code = 4'hE;
         default:  code = 4'hD;
      endcase
      return code;
   endfunction

   logic [3:0]       r_row_meta;
   logic [3:0]       r_row_sync;
   logic [DIV_W-1:0] r_div_cnt;
   logic [1:0]       r_col_idx;
   logic [3:0]       r_col;
   cls_t             r_acc_cls;
   logic [3:0]       r_acc_code;
   cls_t             r_prev_cls;
   logic [3:0]       r_prev_code;
   logic [DB_W-1:0]  r_db_cnt;
   logic             r_stable_held;
   logic [3:0]       r_stable_code;
   logic             r_push_req;
   logic [3:0]       r_push_code;
   logic [3:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_ovf;
   logic             r_irq;

   logic [3:0]       w_row_code [4];
   cls_t             w_col_cls;
   logic [3:0]       w_col_code;
   cls_t             w_frame_cls;
   logic [3:0]       w_frame_code;
   logic             w_sample;
   logic             w_frame_done;
   logic             w_same;
   logic [DB_W-1:0]  w_db_next;
   logic             w_differs;
   logic             w_accept;
   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_stat_rd;
   logic             w_push_ok;
   logic             w_ovf_set;
   logic [2:0]       w_count3;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_row
         assign w_row_code[gi] = key_code(2'(gi), r_col_idx);
      end
      if (CNT_W >= 3) begin : g_cnt_wide
         assign w_count3 = r_count[2:0];
      end else begin : g_cnt_narrow
         assign w_count3 = {{(3 - CNT_W){1'b0}}, r_count};
      end
   endgenerate

   assign w_sample     = (r_div_cnt == DIV_LAST);
   assign w_frame_done = w_sample && (r_col_idx == 2'd3);

   // Classify the keys seen in the column currently being sampled.
   always_comb begin
      w_col_cls  = CLS_NONE;
      w_col_code = 4'h0;
      for (int r = 0; r < 4; r++) begin
         if (!r_row_sync[r]) begin
            if (w_col_cls == CLS_NONE) begin
               w_col_cls  = CLS_ONE;
               w_col_code = w_row_code[r];
            end else begin
               w_col_cls = CLS_MULTI;
            end
         end
      end
   end

   always_comb begin
      w_frame_cls  = r_acc_cls;
      w_frame_code = r_acc_code;
      if (w_col_cls == CLS_MULTI || (w_col_cls == CLS_ONE && r_acc_cls != CLS_NONE)) begin
         w_frame_cls = CLS_MULTI;
      end else if (w_col_cls == CLS_ONE) begin
         w_frame_cls  = CLS_ONE;
         w_frame_code = w_col_code;
      end
   end

   always_comb begin
      w_same    = (w_frame_cls == r_prev_cls) &&
                  (w_frame_cls != CLS_ONE || w_frame_code == r_prev_code);
      w_db_next = DB_W'(1);
      if (w_frame_cls == CLS_MULTI) begin
         w_db_next = '0;
      end else if (w_same) begin
         w_db_next = (r_db_cnt == DB_MAX) ? r_db_cnt : r_db_cnt + 1'b1;
      end
      w_differs = (r_stable_held != (w_frame_cls == CLS_ONE)) ||
                  (w_frame_cls == CLS_ONE && w_frame_code != r_stable_code);
      w_accept  = (w_frame_cls != CLS_MULTI) && (w_db_next == DB_MAX) && w_differs;
   end

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == FIFO_FULL);
   assign w_pop     = re && !addr && !w_empty && !reset;
   assign w_stat_rd = re && addr;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign w_push_ok = r_push_req && (!w_full || w_pop);
   assign w_ovf_set = r_push_req && w_full && !w_pop;

   always_comb begin
      data_out = 8'h00;
      if (re && !reset) begin
         if (addr) begin
            data_out = {1'b0, w_count3, r_stable_held, r_ovf, w_full, !w_empty};
         end else if (!w_empty) begin
            data_out = {4'b0001, r_mem[r_rd_ptr]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= r_push_code;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_row_meta    <= 4'hF;
         r_row_sync    <= 4'hF;
         r_div_cnt     <= '0;
         r_col_idx     <= 2'd0;
         r_col         <= 4'b1110;
         r_acc_cls     <= CLS_NONE;
         r_acc_code    <= 4'h0;
         r_prev_cls    <= CLS_NONE;
         r_prev_code   <= 4'h0;
         r_db_cnt      <= '0;
         r_stable_held <= 1'b0;
         r_stable_code <= 4'h0;
         r_push_req    <= 1'b0;
         r_push_code   <= 4'h0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_ovf         <= 1'b0;
         r_irq         <= 1'b0;
      end else begin
         r_row_meta <= row;
         r_row_sync <= r_row_meta;

         if (w_sample) begin
            r_div_cnt <= '0;
            r_col_idx <= r_col_idx + 2'd1;
            r_col     <= {r_col[2:0], r_col[3]};
            if (w_frame_done) begin
               r_acc_cls   <= CLS_NONE;
               r_acc_code  <= 4'h0;
               r_prev_cls  <= w_frame_cls;
               r_prev_code <= w_frame_code;
               r_db_cnt    <= w_db_next;
               if (w_accept) begin
                  r_stable_held <= (w_frame_cls == CLS_ONE);
                  r_stable_code <= w_frame_code;
               end
            end else begin
               r_acc_cls  <= w_frame_cls;
               r_acc_code <= w_frame_code;
            end
         end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
         end

         r_push_req  <= w_frame_done && w_accept && (w_frame_cls == CLS_ONE);
         r_push_code <= w_frame_code;

         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push_ok && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push_ok && w_pop) begin
            r_count <= r_count - 1'b1;
         end

         if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end else if (w_stat_rd) begin
            r_ovf <= 1'b0;
         end

         r_irq <= !w_empty;
      end
   end

   assign col = r_col;
   assign irq = r_irq;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad model drives rows from the scanned column, and a
// frame-level reference model predicts every register read and the irq line.
module tb_keypad_scan_ctrl;
   localparam int SD    = 4;
   localparam int DB    = 2;
   localparam int DEPTH = 4;
   localparam int FRAME = 4 * SD;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] row;
   logic [3:0] col;
   logic       re = 1'b0;
   logic       addr = 1'b0;
   logic [7:0] data_out;
   logic       irq;

   logic [15:0] keys = 16'h0000;
   logic [7:0]  last_rd;
   int n_pass = 0;
   int n_total = 0;

   int legend [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

   // Reference model state, updated once per frame and per read.
   int m_q[$];
   bit m_ovf, m_held, m_pend;
   int m_stable_code, m_prev_kind, m_prev_code, m_cnt, m_pend_code;

   always #5 clk = ~clk;

   keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .row(row), .col(col),
      .re(re), .addr(addr), .data_out(data_out), .irq(irq)
   );

   // Passive keypad: a pressed key shorts its row to the driven column.
   always_comb begin
      logic [3:0] sel;
      row = 4'hF;
      for (int c = 0; c < 4; c++) begin
         sel = ~(4'b0001 << c);
         if (col == sel) begin
            for (int r = 0; r < 4; r++) begin
               if (keys[legend[r][c]]) row[r] = 1'b0;
            end
         end
      end
   end

   task automatic model_reset();
      m_q.delete();
      m_ovf = 0; m_held = 0; m_pend = 0;
      m_stable_code = 0; m_prev_kind = 0; m_prev_code = 0; m_cnt = 0; m_pend_code = 0;
   endtask

   task automatic model_push();
      if (m_pend) begin
         if (m_q.size() < DEPTH) m_q.push_back(m_pend_code);
         else m_ovf = 1;
         m_pend = 0;
      end
   endtask

   task automatic model_read(input logic a, output logic [7:0] exp);
      int n;
      if (!a) begin
         if (m_q.size() > 0) begin
            exp = 8'h10 | 8'(m_q[0]);
            void'(m_q.pop_front());
         end else begin
            exp = 8'h00;
         end
      end else begin
         n = m_q.size();
         exp = {1'b0, 3'(n), m_held, m_ovf, (n == DEPTH), (n != 0)};
         m_ovf = 0;
      end
   endtask

   task automatic model_frame_end(input logic [15:0] k);
      int n, code, kind;
      n = $countones(k);
      code = 0;
      for (int b = 0; b < 16; b++) if (k[b]) code = b;
      kind = (n == 0) ? 0 : ((n == 1) ? 1 : 2);
      if (kind == 2) begin
         m_cnt = 0;
         m_prev_kind = 2;
      end else begin
         if (kind == m_prev_kind && (kind == 0 || code == m_prev_code))
            m_cnt = (m_cnt < DB) ? m_cnt + 1 : DB;
         else
            m_cnt = 1;
         m_prev_kind = kind;
         m_prev_code = code;
         if (m_cnt == DB) begin
            if (kind == 1 && (!m_held || code != m_stable_code)) begin
               m_pend = 1; m_pend_code = code;
               m_held = 1; m_stable_code = code;
            end else if (kind == 0) begin
               m_held = 0;
            end
         end
      end
   endtask

   // One full scan frame with key set k; slot 0 reads on the push cycle, slot 6 mid-frame, -1 none.
   task automatic do_frame(input logic [15:0] k, input int slot, input logic a, input string tag);
      logic [7:0] exp;
      bit ne_before, ne_after;
      keys = k;
      exp = 8'h00;
      ne_before = (m_q.size() != 0);
      if (slot == 0) model_read(a, exp);
      model_push();
      ne_after = (m_q.size() != 0);
      n_total++;
      if (col !== 4'b1110) $display("FAIL %s frame_start_col got %b want 1110", tag, col);
      else n_pass++;
      for (int i = 0; i < FRAME; i++) begin
         if (i == 1) begin
            n_total++;
            if (irq !== ne_before) $display("FAIL %s irq_lag got %b want %b", tag, irq, ne_before);
            else n_pass++;
         end
         if (i == 2) begin
            n_total++;
            if (irq !== ne_after) $display("FAIL %s irq_push got %b want %b", tag, irq, ne_after);
            else n_pass++;
         end
         if (i == slot) begin
            if (slot != 0) model_read(a, exp);
            re = 1'b1; addr = a;
            #1;
            last_rd = data_out;
            n_total++;
            if (data_out !== exp)
               $display("FAIL %s read addr=%0d got %02h want %02h", tag, a, data_out, exp);
            else n_pass++;
         end
         @(negedge clk);
         re = 1'b0;
      end
      model_frame_end(k);
   endtask

   task automatic check_lit(input logic [7:0] got, input logic [7:0] want, input string tag);
      n_total++;
      if (got !== want) $display("FAIL %s got %02h want %02h", tag, got, want);
      else n_pass++;
   endtask

   task automatic test_reset();
      reset = 1'b1; keys = 16'h0; re = 1'b1; addr = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_total++;
      if (col !== 4'b1110 || irq !== 1'b0 || data_out !== 8'h00)
         $display("FAIL reset col=%b irq=%b data_out=%02h want 1110/0/00", col, irq, data_out);
      else n_pass++;
      @(negedge clk);
      re = 1'b0; reset = 1'b0;
      model_reset();
      do_frame(16'h0, 6, 1'b1, "reset_status");
      check_lit(last_rd, 8'h00, "reset_status_lit");
      $display("test_reset done");
   endtask

   task automatic test_press();
      for (int f = 0; f < 3; f++) do_frame(16'h0008, -1, 1'b0, "press_hold");
      n_total++;
      if (irq !== 1'b1) $display("FAIL press_irq got %b want 1", irq);
      else n_pass++;
      do_frame(16'h0, 6, 1'b0, "press_rd1");
      check_lit(last_rd, 8'h13, "press_rd1_lit");
      do_frame(16'h0, 6, 1'b0, "press_rd2");
      check_lit(last_rd, 8'h00, "press_rd2_lit");
      do_frame(16'h0, -1, 1'b0, "press_idle");
      n_total++;
      if (irq !== 1'b0) $display("FAIL press_irq_fall got %b want 0", irq);
      else n_pass++;
      $display("test_press done");
   endtask

   task automatic test_bounce();
      for (int f = 0; f < 6; f++) begin
         do_frame((f % 2 == 0) ? 16'h0020 : 16'h0000, 6, 1'b1, "bounce");
         check_lit(last_rd, 8'h00, "bounce_status_lit");
      end
      $display("test_bounce done");
   endtask

   task automatic test_multi();
      for (int f = 0; f < 4; f++) begin
         do_frame(16'h0202, 6, 1'b1, "multi");
         check_lit(last_rd, 8'h00, "multi_status_lit");
      end
      for (int f = 0; f < 2; f++) do_frame(16'h0002, -1, 1'b0, "multi_single");
      do_frame(16'h0002, 6, 1'b1, "multi_status");
      check_lit(last_rd, 8'h19, "multi_held_lit");
      do_frame(16'h0002, 6, 1'b0, "multi_data");
      check_lit(last_rd, 8'h11, "multi_data_lit");
      for (int f = 0; f < 2; f++) do_frame(16'h0, -1, 1'b0, "multi_release");
      $display("test_multi done");
   endtask

   task automatic test_overflow();
      logic [7:0] want [4] = '{8'h11, 8'h12, 8'h13, 8'h14};
      for (int kc = 1; kc <= 5; kc++)
         for (int f = 0; f < 2; f++) do_frame(16'(1 << kc), -1, 1'b0, "ovf_fill");
      do_frame(16'h0020, 6, 1'b1, "ovf_status1");
      check_lit(last_rd, 8'h4F, "ovf_status1_lit");
      do_frame(16'h0020, 6, 1'b1, "ovf_status2");
      check_lit(last_rd, 8'h4B, "ovf_status2_lit");
      for (int j = 0; j < 4; j++) begin
         do_frame(16'h0, 6, 1'b0, "ovf_drain");
         check_lit(last_rd, want[j], "ovf_drain_lit");
      end
      do_frame(16'h0, 6, 1'b0, "ovf_empty");
      check_lit(last_rd, 8'h00, "ovf_empty_lit");
      $display("test_overflow done");
   endtask

   task automatic test_back_to_back();
      logic [7:0] want [4] = '{8'h12, 8'h13, 8'h14, 8'h16};
      for (int kc = 1; kc <= 4; kc++)
         for (int f = 0; f < 2; f++) do_frame(16'(1 << kc), -1, 1'b0, "b2b_fill");
      for (int f = 0; f < 2; f++) do_frame(16'h0040, -1, 1'b0, "b2b_key6");
      do_frame(16'h0040, 0, 1'b0, "b2b_same_cycle");
      check_lit(last_rd, 8'h11, "b2b_pop_lit");
      do_frame(16'h0040, 6, 1'b1, "b2b_status");
      check_lit(last_rd, 8'h4B, "b2b_status_lit");
      for (int j = 0; j < 4; j++) begin
         do_frame(16'h0, 6, 1'b0, "b2b_drain");
         check_lit(last_rd, want[j], "b2b_drain_lit");
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_mid();
      for (int f = 0; f < 2; f++) do_frame(16'h0080, -1, 1'b0, "rmid_key7");
      for (int f = 0; f < 2; f++) do_frame(16'h0100, -1, 1'b0, "rmid_key8");
      do_frame(16'h0200, -1, 1'b0, "rmid_half9");
      keys = 16'h0200;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      re = 1'b1; addr = 1'b1;
      #1;
      n_total++;
      if (col !== 4'b1110 || irq !== 1'b0 || data_out !== 8'h00)
         $display("FAIL reset_mid col=%b irq=%b data_out=%02h want 1110/0/00", col, irq, data_out);
      else n_pass++;
      @(negedge clk);
      re = 1'b0; reset = 1'b0; keys = 16'h0;
      model_reset();
      do_frame(16'h0, 6, 1'b1, "rmid_status");
      check_lit(last_rd, 8'h00, "rmid_status_lit");
      $display("test_reset_mid done");
   endtask

   task automatic test_random();
      logic [15:0] k;
      int sel, hold, slot;
      for (int g = 0; g < 30; g++) begin
         sel = $urandom_range(0, 9);
         if (sel < 3) k = 16'h0;
         else if (sel < 8) k = 16'(1 << $urandom_range(0, 15));
         else k = 16'((1 << $urandom_range(0, 15)) | (1 << $urandom_range(0, 15)));
         hold = $urandom_range(1, 3);
         for (int f = 0; f < hold; f++) begin
            sel = $urandom_range(0, 9);
            slot = (sel < 5) ? -1 : ((sel < 8) ? 6 : 0);
            do_frame(k, slot, 1'($urandom_range(0, 1)), "random");
         end
      end
      $display("test_random done");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_press();
      test_bounce();
      test_multi();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
